core_fetch: RTL and testbench

Instruction fetch stage of the in-order RV32 pipeline. It sits in front of decode: it owns the fetch PC, issues in-order read requests to instruction memory, buffers returned instruction words with their PCs, and presents them through the producer side of the decode interface. Redirects arrive from the branch unit over the fetch interface; on a redirect the block drops buffered and in-flight wrong-path words.

---
 rtl/core_fetch_pkg.sv | 20 ++
 rtl/core_fetch_if.sv | 21 ++
 rtl/core_fetch_fifo.sv | 68 ++++++
 rtl/core_fetch.sv | 108 ++++++++++
 tb/tb_core_fetch.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_fetch_pkg.sv
// Shared types for the fetch stage: the RV instruction word type (package rv)
// and the buffered fetch entry plus PC helpers (package core_pkg).
// Optional feature macro used by core_fetch: CORE_FETCH_BYPASS_EN.
package rv;
  typedef logic [31:0] instr_t;
endpackage

package core_pkg;
  localparam int RV_ILEN_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    rv::instr_t  ir;
  } fetch_entry_t;

  // Force a PC onto an instruction-word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/core_fetch_if.sv
// Interfaces around the fetch stage:
//   f_if - redirect from the branch unit (master side is the fetch stage).
//   d_if - fetched instruction stream to decode (slave side is the fetch stage).
interface f_if;
  logic [31:0] pc_new;
  logic        pc_load;

  modport master (input pc_new, input pc_load);
  modport slave  (output pc_new, output pc_load);
endinterface

interface d_if;
  logic        valid;
  logic        ready;
  logic        flush;
  logic [31:0] pc;
  rv::instr_t  ir;

  modport slave  (output valid, output pc, output ir, input ready);
  modport master (input valid, input pc, input ir, output ready, output flush);
endinterface

// File: rtl/core_fetch_fifo.sv
// Circular instruction buffer of {pc, ir} entries with synchronous clear.
// Head entry is visible combinationally so decode sees it the cycle after push.
module core_fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Storage: one register per entry, written when the write pointer selects it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_ok && !clr && (int'(wr_ptr) == gi)) begin
        mem[gi] <= wdata;
      end
    end
  end

  // Head of the queue is presented directly to the consumer.
  always_comb begin
    rdata = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; clear has priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/core_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order imem reads under
// a credit limit of DEPTH (outstanding + buffered), buffers returned words and
// hands them to decode. Redirects drop buffered and in-flight wrong-path words.
// Optional: CORE_FETCH_BYPASS_EN lets a response reach decode in its own cycle
// when the buffer is empty.
module core_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  f_if.master         f,
  d_if.slave          d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]  fetch_pc;
  logic [31:0]  resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          accept;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  wentry;

  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req    = !rst && !f.pc_load && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign issue       = imem_req && imem_gnt;

  // A response is kept only when nothing stale is pending and no redirect is
  // happening this very cycle.
  assign accept = imem_rvalid && (discard == '0) && !f.pc_load;
  assign wentry = '{pc: resp_pc, ir: imem_rdata};

`ifdef CORE_FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = accept && fifo_empty;
  assign d.valid   = !fifo_empty || bypass;
  assign d.pc      = fifo_empty ? resp_pc : head.pc;
  assign d.ir      = fifo_empty ? imem_rdata : head.ir;
  assign fifo_pop  = !fifo_empty && d.ready && !f.pc_load;
  assign fifo_push = accept && !(bypass && d.ready) && (!fifo_full || fifo_pop);
`else
  assign d.valid   = !fifo_empty;
  assign d.pc      = head.pc;
  assign d.ir      = head.ir;
  assign fifo_pop  = !fifo_empty && d.ready && !f.pc_load;
  assign fifo_push = accept && (!fifo_full || fifo_pop);
`endif

  core_fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (f.pc_load),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wentry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Request address: jumps on redirect, steps one word per granted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fetch_pc <= RESET_PC;
    else if (f.pc_load) fetch_pc <= align_pc(f.pc_new);
    else if (issue)     fetch_pc <= fetch_pc + 32'(RV_ILEN_BYTES);
  end

  // PC tag for the next kept response; follows accepted words only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            resp_pc <= RESET_PC;
    else if (f.pc_load) resp_pc <= align_pc(f.pc_new);
    else if (accept)    resp_pc <= resp_pc + 32'(RV_ILEN_BYTES);
  end

  // In-flight request counter: +1 per grant, -1 per response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding <= '0;
    else     outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
  end

  // Stale-response counter: on redirect every request still in flight after
  // this cycle is wrong-path; otherwise each response counts it down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                discard <= '0;
    else if (f.pc_load)                     discard <= outstanding - CW'(imem_rvalid);
    else if (imem_rvalid && discard != '0)  discard <= discard - 1'b1;
  end
endmodule

// File: tb/tb_core_fetch.sv
// Directed bench for core_fetch (RESET_PC=0x100, DEPTH=2) with an in-order
// memory model of programmable latency. Instruction word at address A is
// A ^ 32'h13AB_0000. Define CORE_FETCH_BYPASS_EN to exercise the bypass build.
module tb_core_fetch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int cyc = 0;
  int grant_cnt = 0;

  f_if f ();
  d_if d ();

  always #5 clk = ~clk;

  assign imem_gnt = imem_req;

  core_fetch #(
    .RESET_PC (32'h0000_0100),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .f           (f),
    .d           (d),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata)
  );

  function automatic logic [31:0] ir_of(input logic [31:0] a);
    return a ^ 32'h13AB_0000;
  endfunction

  // Memory model: in-order responses, lat cycles after the grant cycle.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      grant_cnt = 0;
      imem_rvalid = 1'b0;
      imem_rdata = 32'h0;
    end else begin
      if (imem_rvalid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + lat);
        grant_cnt++;
      end
      cyc++;
      #1;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ir_of(pend_addr[0]);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  // Decode-side monitor: records every word consumed outside a redirect cycle.
  logic [31:0] got_pc[$];
  logic [31:0] got_ir[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      got_pc.delete();
      got_ir.delete();
    end else if (d.valid && d.ready && !f.pc_load) begin
      got_pc.push_back(d.pc);
      got_ir.push_back(d.ir);
    end
  end

  function automatic logic [31:0] pc_at(input int i);
    return (got_pc.size() > i) ? got_pc[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] ir_at(input int i);
    return (got_ir.size() > i) ? got_ir[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic do_reset(input int l, input logic rdy);
    @(negedge clk);
    rst = 1'b1;
    lat = l;
    d.ready = rdy;
    f.pc_load = 1'b0;
    f.pc_new = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got_pc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lat = 1;
    d.ready = 1'b1;
    d.flush = 1'b0;
    f.pc_load = 1'b0;
    f.pc_new = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h expected 00000100", imem_addr); end
    checks++; if (d.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", d.valid); end
    checks++; if (dut.outstanding !== 2'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", dut.outstanding); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL first_addr: got %h expected 00000100", imem_addr); end
  endtask

  task automatic test_stream();
    do_reset(1, 1'b1);
    @(negedge clk);  // cycle 1: first response on the bus
`ifdef CORE_FETCH_BYPASS_EN
    checks++; if (d.valid !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %b expected 1", d.valid); end
    checks++; if (d.pc !== 32'h100) begin errors++; $display("FAIL bypass_pc: got %h expected 00000100", d.pc); end
    checks++; if (d.ir !== 32'h13AB_0100) begin errors++; $display("FAIL bypass_ir: got %h expected 13ab0100", d.ir); end
    @(negedge clk);
    checks++; if (dut.u_fifo.count !== 2'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", dut.u_fifo.count); end
`else
    checks++; if (d.valid !== 1'b0) begin errors++; $display("FAIL latency_valid: got %b expected 0", d.valid); end
    @(negedge clk);
    checks++; if (d.valid !== 1'b1) begin errors++; $display("FAIL latency_valid2: got %b expected 1", d.valid); end
    checks++; if (d.pc !== 32'h100) begin errors++; $display("FAIL latency_pc: got %h expected 00000100", d.pc); end
`endif
    wait_words(3, 20);
    checks++; if (pc_at(0) !== 32'h100) begin errors++; $display("FAIL stream_pc0: got %h expected 00000100", pc_at(0)); end
    checks++; if (ir_at(0) !== 32'h13AB_0100) begin errors++; $display("FAIL stream_ir0: got %h expected 13ab0100", ir_at(0)); end
    checks++; if (pc_at(1) !== 32'h104) begin errors++; $display("FAIL stream_pc1: got %h expected 00000104", pc_at(1)); end
    checks++; if (ir_at(1) !== 32'h13AB_0104) begin errors++; $display("FAIL stream_ir1: got %h expected 13ab0104", ir_at(1)); end
    checks++; if (pc_at(2) !== 32'h108) begin errors++; $display("FAIL stream_pc2: got %h expected 00000108", pc_at(2)); end
    checks++; if (ir_at(2) !== 32'h13AB_0108) begin errors++; $display("FAIL stream_ir2: got %h expected 13ab0108", ir_at(2)); end
  endtask

  task automatic test_stall();
    do_reset(1, 1'b0);
    repeat (10) @(negedge clk);
    checks++; if (grant_cnt !== 2) begin errors++; $display("FAIL stall_grants: got %0d expected 2", grant_cnt); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req); end
    checks++; if (d.valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", d.valid); end
    checks++; if (d.pc !== 32'h100) begin errors++; $display("FAIL stall_pc: got %h expected 00000100", d.pc); end
    checks++; if (d.ir !== 32'h13AB_0100) begin errors++; $display("FAIL stall_ir: got %h expected 13ab0100", d.ir); end
    d.ready = 1'b1;
    wait_words(4, 30);
    checks++; if (pc_at(0) !== 32'h100) begin errors++; $display("FAIL resume_pc0: got %h expected 00000100", pc_at(0)); end
    checks++; if (pc_at(1) !== 32'h104) begin errors++; $display("FAIL resume_pc1: got %h expected 00000104", pc_at(1)); end
    checks++; if (pc_at(2) !== 32'h108) begin errors++; $display("FAIL resume_pc2: got %h expected 00000108", pc_at(2)); end
    checks++; if (pc_at(3) !== 32'h10C) begin errors++; $display("FAIL resume_pc3: got %h expected 0000010c", pc_at(3)); end
    checks++; if (ir_at(3) !== 32'h13AB_010C) begin errors++; $display("FAIL resume_ir3: got %h expected 13ab010c", ir_at(3)); end
  endtask

  task automatic test_redirect_stale();
    int base;
    do_reset(3, 1'b1);
    @(negedge clk);
    @(negedge clk);  // cycle 2: two requests in flight, none returned
    checks++; if (dut.outstanding !== 2'd2) begin errors++; $display("FAIL stale_outstanding: got %0d expected 2", dut.outstanding); end
    base = got_pc.size();
    f.pc_new = 32'h200;
    f.pc_load = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stale_req_on_load: got %b expected 0", imem_req); end
    @(negedge clk);
    f.pc_load = 1'b0;
    checks++; if (dut.discard !== 2'd2) begin errors++; $display("FAIL stale_discard: got %0d expected 2", dut.discard); end
    wait_words(base + 2, 40);
    checks++; if (pc_at(base) !== 32'h200) begin errors++; $display("FAIL stale_pc0: got %h expected 00000200", pc_at(base)); end
    checks++; if (ir_at(base) !== 32'h13AB_0200) begin errors++; $display("FAIL stale_ir0: got %h expected 13ab0200", ir_at(base)); end
    checks++; if (pc_at(base + 1) !== 32'h204) begin errors++; $display("FAIL stale_pc1: got %h expected 00000204", pc_at(base + 1)); end
    checks++; if (dut.discard !== 2'd0) begin errors++; $display("FAIL stale_discard_end: got %0d expected 0", dut.discard); end
  endtask

  task automatic test_redirect_rvalid();
    int base;
    do_reset(2, 1'b1);
    @(negedge clk);
    @(negedge clk);  // cycle 2: first response arrives with two outstanding
    checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rv_rvalid: got %b expected 1", imem_rvalid); end
    checks++; if (dut.outstanding !== 2'd2) begin errors++; $display("FAIL rv_outstanding: got %0d expected 2", dut.outstanding); end
    base = got_pc.size();
    f.pc_new = 32'h300;
    f.pc_load = 1'b1;
    @(negedge clk);
    f.pc_load = 1'b0;
    checks++; if (dut.discard !== 2'd1) begin errors++; $display("FAIL rv_discard1: got %0d expected 1", dut.discard); end
    @(negedge clk);
    checks++; if (dut.discard !== 2'd0) begin errors++; $display("FAIL rv_discard0: got %0d expected 0", dut.discard); end
    wait_words(base + 1, 30);
    checks++; if (pc_at(base) !== 32'h300) begin errors++; $display("FAIL rv_pc0: got %h expected 00000300", pc_at(base)); end
    checks++; if (ir_at(base) !== 32'h13AB_0300) begin errors++; $display("FAIL rv_ir0: got %h expected 13ab0300", ir_at(base)); end
  endtask

  task automatic test_misaligned();
    int base;
    do_reset(1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    base = got_pc.size();
    f.pc_new = 32'h203;
    f.pc_load = 1'b1;
    @(negedge clk);
    f.pc_load = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mis_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL mis_addr: got %h expected 00000200", imem_addr); end
    wait_words(base + 1, 30);
    checks++; if (pc_at(base) !== 32'h200) begin errors++; $display("FAIL mis_pc0: got %h expected 00000200", pc_at(base)); end
  endtask

  task automatic test_reset_mid();
    do_reset(1, 1'b1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (d.valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", d.valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL mid_addr: got %h expected 00000100", imem_addr); end
    checks++; if (dut.outstanding !== 2'd0) begin errors++; $display("FAIL mid_outstanding: got %0d expected 0", dut.outstanding); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL mid_restart: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
    wait_words(1, 20);
    checks++; if (pc_at(0) !== 32'h100) begin errors++; $display("FAIL mid_pc0: got %h expected 00000100", pc_at(0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_redirect_rvalid();
    test_misaligned();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
